mux_key_rev_search: RTL and testbench
=====================================

Name: mux_key_rev_search

Overview:
- Sequential reverse lookup over the same packed key/data LUT format used by the team's key-select mux.
- Given a data value, it scans the LUT one entry per cycle and returns the key whose data matches, plus the entry index.
- If no entry matches, it returns a hit flag of 0 and a default key.
- Used where the datapath holds a decoded value and must recover its code, e.g. a segment pattern back to a hex digit, or an ASCII code back to a scan code.

Parameters:
- NR_KEY, 2: number of LUT entries (>=1).
- KEY_LEN, 1: key width in bits.
- DATA_LEN, 1: data width in bits.
- HAS_DEFAULT, 0: 1 = drive default_key on a miss; 0 = drive all-zero key on a miss.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- lut  in  NR_KEY*(KEY_LEN+DATA_LEN)  packed table. Entry n = lut[PAIR_LEN*(n+1)-1 : PAIR_LEN*n]; key in the upper KEY_LEN bits, data in the lower DATA_LEN bits.
- default_key  in  KEY_LEN  key returned on a miss when HAS_DEFAULT=1.
- req_valid  in  1  query present.
- req_ready  out  1  block can accept a query.
- req_data  in  DATA_LEN  value to search for.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_hit  out  1  1 = match found.
- resp_key  out  KEY_LEN  matched key, or default/zero on a miss.
- resp_index  out  IDX_W  index of matched entry; 0 on a miss.

Behaviour:
- Constants: PAIR_LEN = KEY_LEN+DATA_LEN; IDX_W = max(1, clog2(NR_KEY)).
- Reset is asynchronous, active-low. While rst_n=0:
  - state=IDLE, idx=0;
  - req_ready=0, resp_valid=0, resp_hit=0, resp_key=0, resp_index=0.
  - req_ready rises in the first cycle after rst_n deasserts.
- States: IDLE, SCAN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at an edge: latch req_data into q_data, idx<=0, go to SCAN.
- SCAN:
  - req_ready=0.
  - Each cycle, compare entry[idx].data with q_data.
  - On equality: resp_key<=entry[idx].key, resp_index<=idx, resp_hit<=1, resp_valid<=1, go to DONE.
  - Else if idx==NR_KEY-1: resp_hit<=0, resp_index<=0, resp_key<=(HAS_DEFAULT ? default_key : 0), resp_valid<=1, go to DONE.
  - Else: idx<=idx+1.
- Match priority: the lowest index wins. Later duplicates are never examined.
- Latency: a match at entry i gives resp_valid high i+1 cycles after the accepting edge. A miss gives resp_valid after NR_KEY cycles.
- DONE:
  - resp_* held stable while resp_valid=1 and resp_ready=0.
  - On resp_ready=1 at an edge: resp_valid<=0, go to IDLE.
  - req_ready=0 in DONE, so no back-to-back accept in the same cycle. The minimum query-to-query spacing is i+3 cycles.
- resp_key, resp_index and resp_hit keep their last values in IDLE. Only resp_valid qualifies them.
- lut and default_key are not latched. They must stay stable from accept until resp_valid. Changing them mid-scan gives a result that reflects the entries as sampled at each step; no error is flagged.
- NR_KEY=1: the scan lasts exactly one cycle; idx never increments.
- idx never exceeds NR_KEY-1, including when NR_KEY is not a power of two.
- Reset mid-SCAN or mid-DONE: immediate return to IDLE with all outputs at reset values; the pending query is lost.
- req_data changing after accept has no effect.

Decomposition:
- Package mux_key_pkg holds:
  - the state enum (IDLE/SCAN/DONE);
  - functions for PAIR_LEN and IDX_W;
  - entry key/data slice helper functions.
- One sub-module, lut_entry_sel: purely combinational, takes lut and idx, outputs entry_key and entry_data. It is reusable by other LUT-walking blocks.

Test Plan:
- Common setup: NR_KEY=4, KEY_LEN=2, DATA_LEN=4, HAS_DEFAULT=1, default_key=2'b11. Entries: 0={2'd0,4'h3}, 1={2'd1,4'h7}, 2={2'd2,4'h7}, 3={2'd3,4'hC}.
- Hit at first entry: req_data=4'h3 -> resp_valid 1 cycle after accept; hit=1, key=0, index=0.
- Duplicate data: req_data=4'h7 -> resp_valid 2 cycles after accept; hit=1, key=1, index=1 (entry 2 ignored).
- Miss: req_data=4'hF -> resp_valid 4 cycles after accept; hit=0, key=2'b11, index=0. Repeat with HAS_DEFAULT=0 -> key=0.
- Backpressure: req_data=4'hC with resp_ready=0 for 5 cycles -> resp_valid, key=3 and index=3 held constant. req_ready stays 0 until 1 cycle after resp_ready=1.
- Reset mid-scan: accept 4'hF, pull rst_n low 2 cycles later -> resp_valid=0 and req_ready=0 immediately, with no clock edge needed. After release, query 4'h3 returns key=0 normally.
- NR_KEY=1, entry {1'b1, 1'b0}: query 0 -> hit=1, key=1 after 1 cycle; query 1 -> hit=0 after 1 cycle.

Source files
------------

// File: rtl/mux_key_pkg.sv
// Shared types and LUT geometry helpers for blocks that walk packed key/data tables.
// Each entry is {key, data}, with entry n occupying bits [PAIR_LEN*(n+1)-1 : PAIR_LEN*n].
package mux_key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int pairLen(input int keyLen, input int dataLen);
    return keyLen + dataLen;
  endfunction

  function automatic int idxW(input int nrKey);
    return (nrKey <= 1) ? 1 : $clog2(nrKey);
  endfunction

  function automatic int entryDataLsb(input int n, input int keyLen, input int dataLen);
    return n * pairLen(keyLen, dataLen);
  endfunction

  function automatic int entryKeyLsb(input int n, input int keyLen, input int dataLen);
    return n * pairLen(keyLen, dataLen) + dataLen;
  endfunction

endpackage

// File: rtl/mux_key_rev_search_lut_entry_sel.sv
// Combinational selector returning the key and data fields of one packed LUT entry.
// Out-of-range indices return zero.
module lut_entry_sel
  import mux_key_pkg::*;
#(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1,
  parameter int IDX_W    = idxW(NR_KEY),
  localparam int PAIR_LEN = pairLen(KEY_LEN, DATA_LEN)
) (
  input  logic [NR_KEY*PAIR_LEN-1:0] i_lut,
  input  logic [IDX_W-1:0]           i_idx,
  output logic [KEY_LEN-1:0]         o_entry_key,
  output logic [DATA_LEN-1:0]        o_entry_data
);

  always_comb begin
    o_entry_key  = '0;
    o_entry_data = '0;
    for (int n = 0; n < NR_KEY; n++) begin
      if (i_idx == IDX_W'(n)) begin
        o_entry_key  = i_lut[entryKeyLsb(n, KEY_LEN, DATA_LEN) +: KEY_LEN];
        o_entry_data = i_lut[entryDataLsb(n, KEY_LEN, DATA_LEN) +: DATA_LEN];
      end
    end
  end

endmodule

// File: rtl/mux_key_rev_search.sv
// Reverse lookup over a packed key/data LUT: scans one entry per cycle and returns
// the key of the lowest-indexed entry whose data matches the query.
module mux_key_rev_search
  import mux_key_pkg::*;
#(
  parameter int NR_KEY      = 2,
  parameter int KEY_LEN     = 1,
  parameter int DATA_LEN    = 1,
  parameter int HAS_DEFAULT = 0,
  localparam int PAIR_LEN   = pairLen(KEY_LEN, DATA_LEN),
  localparam int IDX_W      = idxW(NR_KEY)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NR_KEY*PAIR_LEN-1:0] lut,
  input  logic [KEY_LEN-1:0]         default_key,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DATA_LEN-1:0]        req_data,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_hit,
  output logic [KEY_LEN-1:0]         resp_key,
  output logic [IDX_W-1:0]           resp_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_LEN-1:0]   r_qData;
  logic                  r_reqReady;
  logic                  r_respValid;
  logic                  r_respHit;
  logic [KEY_LEN-1:0]    r_respKey;
  logic [IDX_W-1:0]      r_respIndex;

  state_t                w_nextState;
  logic [IDX_W-1:0]      w_nextIdx;
  logic [DATA_LEN-1:0]   w_nextQData;
  logic                  w_nextValid;
  logic                  w_nextHit;
  logic [KEY_LEN-1:0]    w_nextKey;
  logic [IDX_W-1:0]      w_nextIndex;
  logic [KEY_LEN-1:0]    w_entryKey;
  logic [DATA_LEN-1:0]   w_entryData;
  logic [KEY_LEN-1:0]    w_missKey;

  lut_entry_sel #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN),
    .IDX_W    (IDX_W)
  ) u_entry_sel (
    .i_lut        (lut),
    .i_idx        (r_idx),
    .o_entry_key  (w_entryKey),
    .o_entry_data (w_entryData)
  );

  assign w_missKey = (HAS_DEFAULT != 0) ? default_key : '0;

  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_nextQData = r_qData;
    w_nextValid = r_respValid;
    w_nextHit   = r_respHit;
    w_nextKey   = r_respKey;
    w_nextIndex = r_respIndex;
    case (r_state)
      IDLE: begin
        if (req_valid && r_reqReady) begin
          w_nextQData = req_data;
          w_nextIdx   = '0;
          w_nextState = SCAN;
        end
      end
      SCAN: begin
        if (w_entryData == r_qData) begin
          w_nextKey   = w_entryKey;
          w_nextIndex = r_idx;
          w_nextHit   = 1'b1;
          w_nextValid = 1'b1;
          w_nextState = DONE;
        end else if (r_idx == LAST_IDX) begin
          w_nextKey   = w_missKey;
          w_nextIndex = '0;
          w_nextHit   = 1'b0;
          w_nextValid = 1'b1;
          w_nextState = DONE;
        end else begin
          w_nextIdx = r_idx + 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          w_nextValid = 1'b0;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // req_ready is registered from the next state so it stays low through reset
  // and only rises on the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_qData     <= '0;
      r_reqReady  <= 1'b0;
      r_respValid <= 1'b0;
      r_respHit   <= 1'b0;
      r_respKey   <= '0;
      r_respIndex <= '0;
    end else begin
      r_state     <= w_nextState;
      r_idx       <= w_nextIdx;
      r_qData     <= w_nextQData;
      r_reqReady  <= (w_nextState == IDLE);
      r_respValid <= w_nextValid;
      r_respHit   <= w_nextHit;
      r_respKey   <= w_nextKey;
      r_respIndex <= w_nextIndex;
    end
  end

  assign req_ready  = r_reqReady;
  assign resp_valid = r_respValid;
  assign resp_hit   = r_respHit;
  assign resp_key   = r_respKey;
  assign resp_index = r_respIndex;

endmodule

// File: tb/tb_mux_key_rev_search.sv
// Directed bench for mux_key_rev_search: three instances (4-entry with default key,
// 4-entry without default, 1-entry) driven through one shared request/response path.
module tb_mux_key_rev_search;

  typedef struct {
    int         sel;
    logic [3:0] data;
    logic       hit;
    logic [1:0] key;
    logic [1:0] index;
    int         latency;
    int         hold;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [23:0] lut4;
  logic [1:0]  lutOne;
  logic [1:0]  defKey;
  logic [0:0]  defKeyOne;
  logic        tbReqValid;
  logic [3:0]  tbReqData;
  logic        tbRespReady;
  int          sel;

  int testsRun;
  int failures;

  logic       reqValid0, reqValid1, reqValid2;
  logic       rdy0, vld0, hit0;
  logic [1:0] key0, idx0;
  logic       rdy1, vld1, hit1;
  logic [1:0] key1, idx1;
  logic       rdy2, vld2, hit2;
  logic [0:0] key2, idx2;

  logic       curReady, curValid, curHit;
  logic [1:0] curKey, curIndex;

  assign reqValid0 = tbReqValid && (sel == 0);
  assign reqValid1 = tbReqValid && (sel == 1);
  assign reqValid2 = tbReqValid && (sel == 2);

  mux_key_rev_search #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(4), .HAS_DEFAULT(1)) dut (
    .clk(clk), .rst_n(rst_n), .lut(lut4), .default_key(defKey),
    .req_valid(reqValid0), .req_ready(rdy0), .req_data(tbReqData),
    .resp_valid(vld0), .resp_ready(tbRespReady), .resp_hit(hit0),
    .resp_key(key0), .resp_index(idx0)
  );

  mux_key_rev_search #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(4), .HAS_DEFAULT(0)) dutNoDef (
    .clk(clk), .rst_n(rst_n), .lut(lut4), .default_key(defKey),
    .req_valid(reqValid1), .req_ready(rdy1), .req_data(tbReqData),
    .resp_valid(vld1), .resp_ready(tbRespReady), .resp_hit(hit1),
    .resp_key(key1), .resp_index(idx1)
  );

  mux_key_rev_search #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1), .HAS_DEFAULT(0)) dutOne (
    .clk(clk), .rst_n(rst_n), .lut(lutOne), .default_key(defKeyOne),
    .req_valid(reqValid2), .req_ready(rdy2), .req_data(tbReqData[0:0]),
    .resp_valid(vld2), .resp_ready(tbRespReady), .resp_hit(hit2),
    .resp_key(key2), .resp_index(idx2)
  );

  always_comb begin
    curReady = rdy0; curValid = vld0; curHit = hit0; curKey = key0; curIndex = idx0;
    if (sel == 1) begin
      curReady = rdy1; curValid = vld1; curHit = hit1; curKey = key1; curIndex = idx1;
    end else if (sel == 2) begin
      curReady = rdy2; curValid = vld2; curHit = hit2;
      curKey = {1'b0, key2}; curIndex = {1'b0, idx2};
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Waits for req_ready, performs one accept, then counts edges until resp_valid.
  task automatic applyStimulus(input int s, input logic [3:0] data, output int latency, output bit ok);
    int waited;
    ok = 1'b0;
    latency = 0;
    sel = s;
    waited = 0;
    @(negedge clk);
    while (!curReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!curReady) begin
      checkOutput("reqReadyTimeout", 32'(curReady), 32'd1);
      return;
    end
    tbReqValid = 1'b1;
    tbReqData  = data;
    @(posedge clk);
    #1;
    tbReqValid = 1'b0;
    tbReqData  = ~data;
    while (!curValid && latency < 40) begin
      @(posedge clk);
      #1;
      latency++;
    end
    if (!curValid) begin
      checkOutput("respValidTimeout", 32'(curValid), 32'd1);
      return;
    end
    ok = 1'b1;
  endtask

  task automatic runQuery(input vec_t v, input string tag);
    int  lat;
    bit  ok;
    applyStimulus(v.sel, v.data, lat, ok);
    if (!ok) return;
    checkOutput({tag, ".latency"}, 32'(lat), 32'(v.latency));
    checkOutput({tag, ".hit"}, 32'(curHit), 32'(v.hit));
    checkOutput({tag, ".key"}, 32'(curKey), 32'(v.key));
    checkOutput({tag, ".index"}, 32'(curIndex), 32'(v.index));
    for (int c = 0; c < v.hold; c++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, ".holdValid"}, 32'(curValid), 32'd1);
      checkOutput({tag, ".holdKey"}, 32'(curKey), 32'(v.key));
      checkOutput({tag, ".holdIndex"}, 32'(curIndex), 32'(v.index));
      checkOutput({tag, ".holdReady"}, 32'(curReady), 32'd0);
    end
    @(negedge clk);
    tbRespReady = 1'b1;
    @(posedge clk);
    #1;
    tbRespReady = 1'b0;
    checkOutput({tag, ".validDrop"}, 32'(curValid), 32'd0);
    checkOutput({tag, ".readyBack"}, 32'(curReady), 32'd1);
  endtask

  vec_t vectors[9];

  initial begin
    int  lat;
    bit  ok;
    testsRun    = 0;
    failures    = 0;
    sel         = 0;
    tbReqValid  = 1'b0;
    tbReqData   = 4'h0;
    tbRespReady = 1'b0;
    defKey      = 2'b11;
    defKeyOne   = 1'b1;
    lut4        = {2'd3, 4'hC, 2'd2, 4'h7, 2'd1, 4'h7, 2'd0, 4'h3};
    lutOne      = {1'b1, 1'b0};
    rst_n       = 1'b0;

    vectors[0] = '{0, 4'h3, 1'b1, 2'd0, 2'd0, 1, 0};
    vectors[1] = '{0, 4'h7, 1'b1, 2'd1, 2'd1, 2, 0};
    vectors[2] = '{0, 4'hF, 1'b0, 2'd3, 2'd0, 4, 0};
    vectors[3] = '{0, 4'hC, 1'b1, 2'd3, 2'd3, 4, 5};
    vectors[4] = '{0, 4'h0, 1'b0, 2'd3, 2'd0, 4, 0};
    vectors[5] = '{1, 4'hF, 1'b0, 2'd0, 2'd0, 4, 0};
    vectors[6] = '{1, 4'h7, 1'b1, 2'd1, 2'd1, 2, 1};
    vectors[7] = '{2, 4'h0, 1'b1, 2'd1, 2'd0, 1, 0};
    vectors[8] = '{2, 4'h1, 1'b0, 2'd0, 2'd0, 1, 0};

    #12;
    checkOutput("reset.ready", 32'(rdy0), 32'd0);
    checkOutput("reset.valid", 32'(vld0), 32'd0);
    checkOutput("reset.hit", 32'(hit0), 32'd0);
    checkOutput("reset.key", 32'(key0), 32'd0);
    checkOutput("reset.index", 32'(idx0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("afterReset.ready", 32'(rdy0), 32'd1);

    for (int i = 0; i < 9; i++) begin
      runQuery(vectors[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a scan drops the query without needing a clock edge.
    sel = 0;
    @(negedge clk);
    tbReqValid = 1'b1;
    tbReqData  = 4'hF;
    @(posedge clk);
    #1;
    tbReqValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.valid", 32'(vld0), 32'd0);
    checkOutput("midReset.ready", 32'(rdy0), 32'd0);
    checkOutput("midReset.key", 32'(key0), 32'd0);
    checkOutput("midReset.index", 32'(idx0), 32'd0);
    checkOutput("midReset.hit", 32'(hit0), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("postReset.noStaleResp", 32'(vld0), 32'd0);
    end
    runQuery('{0, 4'h3, 1'b1, 2'd0, 2'd0, 1, 0}, "postReset");

    // Query straight after a hold, with no idle gap other than the forced one.
    applyStimulus(0, 4'h7, lat, ok);
    if (ok) begin
      checkOutput("chain.latency", 32'(lat), 32'd2);
      checkOutput("chain.key", 32'(curKey), 32'd1);
      @(negedge clk);
      tbRespReady = 1'b1;
      @(posedge clk);
      #1;
      tbRespReady = 1'b0;
      checkOutput("chain.idleKeepsKey", 32'(curKey), 32'd1);
      checkOutput("chain.idleKeepsIndex", 32'(curIndex), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
